// File: rtl/rv32_pkg.sv
// rv32_pkg: opcode constants and enums shared by the loader and the control unit
package rv32_pkg;
  typedef enum logic [1:0] {OP_ADDI, OP_BNE, OP_END, OP_RSVD} op_e;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_e;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
endpackage

// File: rtl/rv_instr_encode.sv
// rv_instr_encode: combinational ADDI/BNE encoder with immediate legality check
module rv_instr_encode
  import rv32_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);
  always_comb begin
    word = op == OP_BNE ? {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH}
                        : {imm[11:0], rs1, F3_ADDI, rd, OPC_IMM};
    // ADDI needs imm to fit 12 signed bits; branch offsets must be halfword aligned
    illegal = op == OP_RSVD || (op == OP_ADDI && imm[12] != imm[11]) || (op == OP_BNE && imm[0]);
  end
endmodule

// File: rtl/instr_stream_loader.sv
// instr_stream_loader: encodes ADDI/BNE requests and streams them into instruction memory
module instr_stream_loader
  import rv32_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_INSTR  = 256,
  localparam int CW = $clog2(MAX_INSTR + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [12:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CW-1:0]         instr_count
);
  state_e state, nstate;
  op_e op;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0] word;
  logic illegal, accept, is_instr, full, bad, wr;
  assign op = op_e'(in_op);
  rv_instr_encode u_enc (
    .op(op), .rd(in_rd), .rs1(in_rs1), .rs2(in_rs2), .imm(in_imm),
    .word(word), .illegal(illegal)
  );
  always_comb begin
    in_ready = state == LOAD;
    busy     = state != IDLE;
    accept   = in_valid && in_ready;
    is_instr = op == OP_ADDI || op == OP_BNE;
    full     = instr_count == CW'(MAX_INSTR);
    bad      = accept && (illegal || (is_instr && full));
    wr       = accept && is_instr && !illegal && !full;
    nstate   = state == IDLE  ? (start ? LOAD : IDLE)
             : state == FLUSH ? IDLE
             : bad            ? IDLE
             : (accept && op == OP_END) ? FLUSH : LOAD;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= nstate;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      instr_count <= '0;
      addr_q      <= '0;
    end else begin
      mem_we <= wr;
      done   <= state == FLUSH;
      if (state == IDLE && start) begin
        addr_q      <= base_addr & ~ADDR_WIDTH'(3);
        err         <= 1'b0;
        instr_count <= '0;
      end
      if (wr) begin
        mem_addr    <= addr_q;
        mem_wdata   <= word;
        addr_q      <= addr_q + ADDR_WIDTH'(4);
        instr_count <= instr_count + CW'(1);
      end
      if (bad) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader: directed checks of encoding, addressing, errors and reset
module tb_instr_stream_loader;
  logic clk = 0;
  logic rst = 1, start = 0, in_valid = 0;
  logic [31:0] base_addr = 0;
  logic [1:0] in_op = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [12:0] in_imm = 0;
  logic in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [8:0] instr_count;
  logic in_ready2, mem_we2, busy2, done2, err2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [1:0] instr_count2;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  instr_stream_loader #(.ADDR_WIDTH(32), .MAX_INSTR(256)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .instr_count(instr_count)
  );

  instr_stream_loader #(.ADDR_WIDTH(32), .MAX_INSTR(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .in_valid(in_valid),
    .in_ready(in_ready2), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .busy(busy2), .done(done2), .err(err2), .instr_count(instr_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [12:0] imm);
    in_valid = 1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic begin_session(input logic [31:0] base);
    start = 1; base_addr = base;
    step();
    start = 0;
  endtask

  logic [31:0] t3_data [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
  logic [12:0] bad_imm [3] = '{13'h0800, 13'h0003, 13'h0000};
  logic [1:0]  bad_op  [3] = '{2'd0, 2'd1, 2'd3};

  initial begin
    step(); step();
    rst = 0;
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_count", instr_count, 0);

    // ADDI then BNE then END from base 0
    begin_session(32'h0);
    check("t1_in_ready", in_ready, 1);
    check("t1_busy", busy, 1);
    req(2'd0, 5'd1, 5'd0, 5'd0, 13'd5);
    step();
    check("t1_we", mem_we, 1);
    check("t1_addr", mem_addr, 32'h0);
    check("t1_data", mem_wdata, 32'h00500093);
    check("t1_count", instr_count, 1);
    req(2'd1, 5'd0, 5'd1, 5'd0, 13'h1FFC);
    step();
    check("t2_we", mem_we, 1);
    check("t2_addr", mem_addr, 32'h4);
    check("t2_data", mem_wdata, 32'hFE009EE3);
    check("t2_count", instr_count, 2);
    req(2'd2, 5'd0, 5'd0, 5'd0, 13'd0);
    step();
    in_valid = 0;
    check("t1_flush_we", mem_we, 0);
    check("t1_flush_ready", in_ready, 0);
    check("t1_flush_busy", busy, 1);
    check("t1_flush_done", done, 0);
    step();
    check("t1_done", done, 1);
    check("t1_idle_busy", busy, 0);
    check("t1_err", err, 0);
    step();
    check("t1_done_pulse", done, 0);

    // back-to-back ADDIs from 0x100
    begin_session(32'h100);
    for (int i = 0; i < 4; i++) begin
      req(2'd0, 5'(i + 1), 5'd0, 5'd0, 13'(i + 1));
      step();
      check($sformatf("t3_we%0d", i), mem_we, 1);
      check($sformatf("t3_addr%0d", i), mem_addr, 32'h100 + 32'(4 * i));
      check($sformatf("t3_data%0d", i), mem_wdata, t3_data[i]);
    end
    req(2'd2, 5'd0, 5'd0, 5'd0, 13'd0);
    step();
    in_valid = 0;
    step();
    check("t3_done", done, 1);
    check("t3_count", instr_count, 4);

    // illegal ADDI imm, odd BNE offset, reserved op
    for (int i = 0; i < 3; i++) begin
      begin_session(32'h200);
      check($sformatf("t4_err_clr%0d", i), err, 0);
      req(bad_op[i], 5'd2, 5'd3, 5'd4, bad_imm[i]);
      step();
      in_valid = 0;
      check($sformatf("t4_we%0d", i), mem_we, 0);
      check($sformatf("t4_err%0d", i), err, 1);
      check($sformatf("t4_idle%0d", i), busy, 0);
      step();
      check($sformatf("t4_nodone%0d", i), done, 0);
      check($sformatf("t4_sticky%0d", i), err, 1);
    end

    // capacity limit and address wrap on the MAX_INSTR=2 instance
    begin_session(32'hFFFFFFFC);
    check("t5_err_clr", err2, 0);
    req(2'd0, 5'd1, 5'd0, 5'd0, 13'd1);
    step();
    check("t5_we0", mem_we2, 1);
    check("t5_addr0", mem_addr2, 32'hFFFFFFFC);
    req(2'd0, 5'd2, 5'd0, 5'd0, 13'd2);
    step();
    check("t5_we1", mem_we2, 1);
    check("t5_addr1", mem_addr2, 32'h0);
    check("t5_count", instr_count2, 2);
    req(2'd0, 5'd3, 5'd0, 5'd0, 13'd3);
    step();
    in_valid = 0;
    check("t5_we2", mem_we2, 0);
    check("t5_err", err2, 1);
    check("t5_idle", busy2, 0);
    step();
    check("t5_nodone", done2, 0);

    // reset the cycle after an accept (dut is still in LOAD)
    check("t6_loading", busy, 1);
    req(2'd0, 5'd5, 5'd0, 5'd0, 13'd7);
    step();
    in_valid = 0;
    rst = 1;
    step();
    check("t6_we", mem_we, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", in_ready, 0);
    check("t6_count", instr_count, 0);
    check("t6_addr", mem_addr, 0);
    check("t6_wdata", mem_wdata, 0);
    check("t6_err2", err2, 0);
    start = 1;
    step();
    check("t6_rst_wins", busy, 0);
    rst = 0; start = 0;
    step();
    check("t6_still_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
